lcd_hd44780_sequencer: RTL and testbench
========================================

# lcd_hd44780_sequencer

Avalon-MM slave that drives the 11-bit character-LCD bus with correct HD44780 bus timing. Software pushes command/data bytes into a small FIFO; the block generates RS/RW/E sequencing and per-command execution delays, and optionally runs the power-on initialisation itself. It replaces direct bit-banging of the LCD output port, so the CPU never spins on LCD timing.

## Interface
Parameters:
- FIFO_DEPTH, 8: command FIFO entries, power of two, 2..64
- SETUP_CYCLES, 4: RS/DB valid before E rises (tAS)
- PULSE_CYCLES, 25: E high width
- HOLD_CYCLES, 2: RS/DB held after E falls
- EXEC_CYCLES, 2500: wait after ordinary command/data (50 µs @ 50 MHz)
- CLEAR_CYCLES, 82000: wait after Clear (0x01) / Home (0x02–0x03), RS=0
- POWERUP_CYCLES, 750000: delay before first init command

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read data, zero wait states
- out_port  out  11  LCD bus: [7:0] DB, [8] RS, [9] RW (always 0), [10] E

## Operation
- Addr 0 write: push {writedata[8]=RS, writedata[7:0]=DB}. Write when FIFO full is dropped; sets sticky overflow.
- Addr 1 read: [0] busy (FSM not IDLE or FIFO non-empty), [1] full, [2] empty, [3] init_done, [4] overflow, [11:8] FIFO level (zero-extended); other bits 0. Addr 1 write with writedata[4]=1 clears overflow.
- Addr 0 read returns last pushed entry in [8:0]; addr 2/3 read 0, writes ignored.
- FSM: POWERUP -> INIT -> IDLE -> SETUP -> PULSE -> HOLD -> EXEC -> IDLE.
- POWERUP: count POWERUP_CYCLES, E=0. INIT: issues 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (RS=0) through SETUP/PULSE/HOLD/EXEC, ignoring FIFO; init_done=1 after last EXEC.
- IDLE with FIFO non-empty: pop one entry, latch into out_port DB/RS, go SETUP.
- EXEC length: CLEAR_CYCLES when RS=0 and DB[7:2]=0 and DB[1:0]!=0; else EXEC_CYCLES.
- DB/RS stay at last value from SETUP until next SETUP.
- Simultaneous push and pop: both occur, level unchanged. Full is evaluated before the same-cycle pop: write at full is dropped even if a pop occurs.
- FIFO accepts pushes during POWERUP/INIT; they execute after init_done.
- Single down-counter, width $clog2(max of all cycle parameters)+1, shared across states.

## Timing
- Reset: out_port=0, readdata reflects reset state (empty=1, others 0), FIFO flushed, overflow=0, init_done=0, FSM=POWERUP. Reset mid-transfer aborts immediately; E low the cycle after the reset edge.
- Push accepted at edge N; level/empty update after N.
- IDLE pop at edge N+1; DB/RS on out_port from N+1; E rises at N+1+SETUP_CYCLES, high exactly PULSE_CYCLES cycles, then HOLD_CYCLES, then EXEC wait; IDLE re-entered SETUP+PULSE+HOLD+EXEC cycles after pop.
- Back-to-back entries: next pop on the first IDLE cycle; no extra bubble.
- Level counter saturates at FIFO_DEPTH, never wraps; pointers wrap modulo FIFO_DEPTH.

## Configuration
- LCD_AUTO_INIT_EN defined: POWERUP and INIT states built as above.
- Not defined: reset enters IDLE directly, init_done reads 1, POWERUP_CYCLES unused; software performs initialisation through the FIFO.

## Structure
- Package lcd_seq_pkg: FSM state enum, out_port bit indices (DB_LSB, RS_BIT, RW_BIT, E_BIT), register address constants, status bit positions, init command ROM constant.
- Sub-module lcd_cmd_fifo: synchronous 9-bit FIFO with push/pop, full/empty, level; no output register.

## Test plan
- Bench parameters SETUP=2, PULSE=3, HOLD=1, EXEC=5, CLEAR=20, POWERUP=10; macro defined: after reset, E pulses exactly 6 times with DB 0x38,0x38,0x38,0x0C,0x01,0x06; gap after 0x01 is 20 cycles; init_done=1 afterwards.
- Push 0x141 (RS=1, 'A') in IDLE: DB=0x41, RS=1 one cycle after pop; E high 3 cycles starting 2 cycles later; busy clears 11 cycles after pop.
- Push 9 entries with DEPTH=8 while busy: 9th dropped, status overflow=1, full=1; write addr1 0x10 clears overflow; exactly 8 E pulses follow in order.
- Push 0x002 (Home) then 0x003: both use 20-cycle EXEC; 0x004 uses 5.
- Assert reset while E high: out_port=0 next cycle, empty=1, FSM restarts POWERUP.
- Macro undefined: init_done=1 right after reset; first push pulses E without init commands.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the HD44780 LCD bus sequencer.
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } state_e;

    // FIFO entry: RS above the 8-bit DB byte
    typedef struct packed {
        logic       rs;
        logic [7:0] db;
    } lcd_entry_t;

    localparam int unsigned ENTRY_W = 9;

    // out_port bit map
    localparam int unsigned BUS_W  = 11;
    localparam int unsigned DB_LSB = 0;
    localparam int unsigned DB_W   = 8;
    localparam int unsigned RS_BIT = 8;
    localparam int unsigned RW_BIT = 9;
    localparam int unsigned E_BIT  = 10;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;

    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_EMPTY_BIT = 2;
    localparam int unsigned STAT_INIT_BIT  = 3;
    localparam int unsigned STAT_OVF_BIT   = 4;
    localparam int unsigned STAT_LVL_LSB   = 8;
    localparam int unsigned STAT_LVL_W     = 4;

    // Power-on init: function set x3, display on, clear, entry mode
    localparam int unsigned INIT_LEN = 6;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO of RS/DB entries; read data is the head entry, unregistered.
module lcd_cmd_fifo
    import lcd_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  lcd_entry_t       wdata_i,
    input  logic             pop_i,
    output lcd_entry_t       rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    lcd_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem[rd_ptr_q];

    // Full is judged on the pre-edge level, so a same-cycle pop never rescues a push at full
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok) level_d = level_q + 1'b1;
        if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/lcd_hd44780_sequencer.sv
// Avalon-MM HD44780 bus sequencer: FIFO'd commands are played out with RS/E timing and exec waits.
// Define LCD_AUTO_INIT_EN to build the power-up delay and init command sequence into the FSM.
module lcd_hd44780_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned PULSE_CYCLES   = 25,
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter int unsigned EXEC_CYCLES    = 2500,
    parameter int unsigned CLEAR_CYCLES   = 82000,
    parameter int unsigned POWERUP_CYCLES = 750000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [BUS_W-1:0]  out_port
);

    localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYCLES, PULSE_CYCLES),
                                                  max_u(HOLD_CYCLES, EXEC_CYCLES)),
                                            max_u(CLEAR_CYCLES, POWERUP_CYCLES));
    localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       db_q, db_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    lcd_entry_t       last_q, last_d;
    logic             ovf_q, ovf_d;

    logic             wr_c;
    logic             push_c;
    logic             pop_c;
    logic             busy_c;
    logic             is_clear_c;
    logic             init_done_c;
    lcd_entry_t       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic             unused_wdata;

`ifdef LCD_AUTO_INIT_EN
    logic [2:0]       init_idx_q, init_idx_d;
    logic             in_init_q, in_init_d;
    logic             init_done_q, init_done_d;
    assign init_done_c = init_done_q;
`else
    assign init_done_c = 1'b1;
`endif

    assign unused_wdata = ^writedata[31:9];

    assign wr_c       = chipselect && !write_n;
    assign push_c     = wr_c && (address == ADDR_DATA);
    assign busy_c     = (state_q != ST_IDLE) || !fifo_empty;
    assign is_clear_c = !rs_q && (db_q[7:2] == 6'd0) && (db_q[1:0] != 2'd0);

    lcd_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .wdata_i (lcd_entry_t'(writedata[ENTRY_W-1:0])),
        .pop_i   (pop_c),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Register file: last accepted entry and sticky overflow
    always_comb begin
        last_d = last_q;
        ovf_d  = ovf_q;
        if (push_c && !fifo_full) last_d = lcd_entry_t'(writedata[ENTRY_W-1:0]);
        if (push_c && fifo_full)  ovf_d  = 1'b1;
        if (wr_c && (address == ADDR_STATUS) && writedata[STAT_OVF_BIT]) ovf_d = 1'b0;
    end

    // Bus sequencing FSM; one down-counter times every state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rs_d    = rs_q;
        e_d     = e_q;
        pop_c   = 1'b0;
`ifdef LCD_AUTO_INIT_EN
        init_idx_d  = init_idx_q;
        in_init_d   = in_init_q;
        init_done_d = init_done_q;
`endif
        case (state_q)
`ifdef LCD_AUTO_INIT_EN
            ST_POWERUP: begin
                if (cnt_q == '0) state_d = ST_INIT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_INIT: begin
                db_d       = INIT_ROM[init_idx_q];
                rs_d       = 1'b0;
                init_idx_d = init_idx_q + 1'b1;
                in_init_d  = 1'b1;
                cnt_d      = SETUP_LD;
                state_d    = ST_SETUP;
            end
`endif
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    db_d    = fifo_head.db;
                    rs_d    = fifo_head.rs;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    e_d     = 1'b1;
                    cnt_d   = PULSE_LD;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    e_d     = 1'b0;
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = is_clear_c ? CLEAR_LD : EXEC_LD;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
`ifdef LCD_AUTO_INIT_EN
                    if (in_init_q) begin
                        if (init_idx_q == 3'(INIT_LEN)) begin
                            in_init_d   = 1'b0;
                            init_done_d = 1'b1;
                        end else begin
                            state_d = ST_INIT;
                        end
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef LCD_AUTO_INIT_EN
            state_q     <= ST_POWERUP;
            cnt_q       <= CNT_W'(POWERUP_CYCLES - 1);
            init_idx_q  <= '0;
            in_init_q   <= 1'b0;
            init_done_q <= 1'b0;
`else
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
`endif
            db_q        <= '0;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            last_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
`ifdef LCD_AUTO_INIT_EN
            init_idx_q  <= init_idx_d;
            in_init_q   <= in_init_d;
            init_done_q <= init_done_d;
`endif
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            db_q        <= db_d;
            rs_q        <= rs_d;
            e_q         <= e_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        out_port                      = '0;
        out_port[DB_LSB +: DB_W]      = db_q;
        out_port[RS_BIT]              = rs_q;
        out_port[RW_BIT]              = 1'b0;
        out_port[E_BIT]               = e_q;
    end

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata = 32'(last_q);
            ADDR_STATUS: begin
                readdata[STAT_BUSY_BIT]                = busy_c;
                readdata[STAT_FULL_BIT]                = fifo_full;
                readdata[STAT_EMPTY_BIT]               = fifo_empty;
                readdata[STAT_INIT_BIT]                = init_done_c;
                readdata[STAT_OVF_BIT]                 = ovf_q;
                readdata[STAT_LVL_LSB +: STAT_LVL_W]   = STAT_LVL_W'(fifo_level);
            end
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_lcd_hd44780_sequencer.sv
// Self-checking bench for lcd_hd44780_sequencer: register vector table plus a pulse scoreboard.
module tb_lcd_hd44780_sequencer;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned SETUP   = 2;
    localparam int unsigned PULSE   = 3;
    localparam int unsigned HOLD    = 1;
    localparam int unsigned EXEC    = 5;
    localparam int unsigned CLEAR   = 20;
    localparam int unsigned POWERUP = 10;

    localparam int GAP_EXEC  = HOLD + EXEC + 1 + SETUP;
    localparam int GAP_CLEAR = HOLD + CLEAR + 1 + SETUP;

`ifdef LCD_AUTO_INIT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam logic [31:0] RESET_STATUS = AUTO ? 32'h5 : 32'hC;
    localparam logic [31:0] IDLE_STATUS  = 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd1;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [10:0] out_port;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [8:0] data;
        int         gap;
    } exp_t;
    exp_t exp_q [$];

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic        acc;
        int          gap;
        logic        chk;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl [18];

    logic [8:0] home_v [4];
    int         home_g [4];

    lcd_hd44780_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .SETUP_CYCLES   (SETUP),
        .PULSE_CYCLES   (PULSE),
        .HOLD_CYCLES    (HOLD),
        .EXEC_CYCLES    (EXEC),
        .CLEAR_CYCLES   (CLEAR),
        .POWERUP_CYCLES (POWERUP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] a, input logic w, input logic [31:0] d,
                                input logic acc, input int gap, input logic c, input logic [31:0] e);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = d; v.acc = acc; v.gap = gap; v.chk = c; v.exp_rd = e;
        return v;
    endfunction

    task automatic push_init_exp();
        exp_t x;
        for (int i = 0; i < 6; i++) begin
            x.data = (i < 3) ? 9'h038 : (i == 3) ? 9'h00C : (i == 4) ? 9'h001 : 9'h006;
            x.gap  = (i == 0) ? -1 : (i == 5) ? GAP_CLEAR : GAP_EXEC;
            exp_q.push_back(x);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    endtask

    task automatic release_bus();
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
    endtask

    task automatic wait_idle(input string name);
        logic done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            address = 2'd1;
            #1;
            if (!readdata[0] && exp_q.size() == 0) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // Pulse monitor: checks DB/RS at each E rise, E width, and low gap between pulses
    int   mon_hi = 0;
    int   mon_gap = 0;
    logic mon_gap_ok = 1'b0;
    logic mon_eprev = 1'b0;
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (reset) begin
            mon_eprev  = 1'b0;
            mon_hi     = 0;
            mon_gap_ok = 1'b0;
        end else begin
            if (out_port[10] && !mon_eprev) begin
                chk("rw_low", 32'(out_port[9]), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse actual=0x%0h required=none at %0t", out_port[8:0], $time);
                end else begin
                    x = exp_q.pop_front();
                    chk("pulse_data", 32'(out_port[8:0]), 32'(x.data));
                    if (x.gap >= 0 && mon_gap_ok) chk("pulse_gap", 32'(mon_gap), 32'(x.gap));
                end
                mon_hi = 1;
            end else if (out_port[10]) begin
                mon_hi++;
            end else if (mon_eprev) begin
                chk("e_width", 32'(mon_hi), 32'(PULSE));
                mon_gap    = 1;
                mon_gap_ok = 1'b1;
            end else begin
                mon_gap++;
            end
            mon_eprev = out_port[10];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t x;
        logic seen;

        tbl[0]  = mk(2'd0, 1'b1, 32'h130, 1'b1, -1, 1'b0, 32'h0);
        tbl[1]  = mk(2'd1, 1'b0, 32'h0,   1'b0, -1, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++)
            tbl[2+i] = mk(2'd0, 1'b1, 32'h141 + 32'(i), (i < 8), GAP_EXEC, 1'b0, 32'h0);
        tbl[11] = mk(2'd1, 1'b0, 32'h0,    1'b0, -1, 1'b1, 32'h81B);
        tbl[12] = mk(2'd1, 1'b1, 32'h10,   1'b0, -1, 1'b0, 32'h0);
        tbl[13] = mk(2'd1, 1'b0, 32'h0,    1'b0, -1, 1'b1, 32'h80B);
        tbl[14] = mk(2'd0, 1'b0, 32'h0,    1'b0, -1, 1'b1, 32'h148);
        tbl[15] = mk(2'd2, 1'b1, 32'hFFFF, 1'b0, -1, 1'b0, 32'h0);
        tbl[16] = mk(2'd2, 1'b0, 32'h0,    1'b0, -1, 1'b1, 32'h0);
        tbl[17] = mk(2'd3, 1'b0, 32'h0,    1'b0, -1, 1'b1, 32'h0);

        home_v[0] = 9'h002; home_g[0] = -1;
        home_v[1] = 9'h003; home_g[1] = GAP_CLEAR;
        home_v[2] = 9'h004; home_g[2] = GAP_CLEAR;
        home_v[3] = 9'h005; home_g[3] = GAP_EXEC;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_port", 32'(out_port), 32'h0);
        chk("reset_status", readdata, RESET_STATUS);
        address = 2'd0;
        #1;
        chk("reset_last", readdata, 32'h0);
        address = 2'd1;
        reset = 1'b0;
        if (AUTO) push_init_exp();
        wait_idle("init_complete");
        #1;
        chk("idle_status", readdata, IDLE_STATUS);

        // Single push: DB/RS one cycle after pop, E rises SETUP later, idle after 11 cycles
        write_reg(2'd0, 32'h141);
        x.data = 9'h141; x.gap = -1;
        exp_q.push_back(x);
        release_bus();
        @(negedge clk);
        #1;
        chk("single_dbrs", 32'(out_port[8:0]), 32'h141);
        chk("single_e_k0", 32'(out_port[10]), 32'd0);
        chk("single_busy_k0", 32'(readdata[0]), 32'd1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            #1;
            if (k == 1)  chk("single_e_k1", 32'(out_port[10]), 32'd0);
            if (k == 2)  chk("single_e_k2", 32'(out_port[10]), 32'd1);
            if (k == 4)  chk("single_e_k4", 32'(out_port[10]), 32'd1);
            if (k == 5)  chk("single_e_k5", 32'(out_port[10]), 32'd0);
            if (k == 10) chk("single_busy_k10", 32'(readdata[0]), 32'd1);
            if (k == 11) chk("single_busy_k11", 32'(readdata[0]), 32'd0);
        end
        wait_idle("single_idle");

        // Register table: overflow with depth 8, clear, readback of other addresses
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            address    = tbl[i].addr;
            chipselect = 1'b1;
            write_n    = !tbl[i].wr;
            writedata  = tbl[i].wdata;
            if (tbl[i].wr && tbl[i].addr == 2'd0 && tbl[i].acc) begin
                x.data = tbl[i].wdata[8:0];
                x.gap  = tbl[i].gap;
                exp_q.push_back(x);
            end
            #1;
            if (tbl[i].chk) chk($sformatf("vec%0d_rd", i), readdata, tbl[i].exp_rd);
        end
        release_bus();
        wait_idle("table_drain");

        // Home/clear commands take the long exec wait
        for (int i = 0; i < 4; i++) begin
            write_reg(2'd0, 32'(home_v[i]));
            x.data = home_v[i]; x.gap = home_g[i];
            exp_q.push_back(x);
        end
        release_bus();
        wait_idle("home_drain");

        // Reset while E is high: bus drops next cycle and the queued second entry is flushed
        write_reg(2'd0, 32'h141);
        x.data = 9'h141; x.gap = -1;
        exp_q.push_back(x);
        write_reg(2'd0, 32'h142);
        release_bus();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (out_port[10]) seen = 1'b1;
        end
        chk("e_seen_before_reset", 32'(seen), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midreset_out_port", 32'(out_port), 32'h0);
        chk("midreset_status", readdata, RESET_STATUS);
        reset = 1'b0;
        if (AUTO) push_init_exp();
        wait_idle("post_reset_idle");
        repeat (20) @(negedge clk);
        #1;
        chk("final_status", readdata, IDLE_STATUS);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
